// File: rtl/rtc_pkg.sv
// Shared definitions for the RTC bus reader: scan/phase state encodings,
// register index map and the RTC address of each scanned register.
package rtc_pkg;

  localparam int NUM_REGS = 9;

  localparam logic [3:0] IDX_SEGUNDO  = 4'd0;
  localparam logic [3:0] IDX_MINUTO   = 4'd1;
  localparam logic [3:0] IDX_HORA     = 4'd2;
  localparam logic [3:0] IDX_DIA      = 4'd3;
  localparam logic [3:0] IDX_MES      = 4'd4;
  localparam logic [3:0] IDX_ANO      = 4'd5;
  localparam logic [3:0] IDX_SEGUNDOT = 4'd6;
  localparam logic [3:0] IDX_MINUTOT  = 4'd7;
  localparam logic [3:0] IDX_HORAT    = 4'd8;

  localparam logic [7:0] ADDR_SEGUNDO  = 8'h21;
  localparam logic [7:0] ADDR_MINUTO   = 8'h22;
  localparam logic [7:0] ADDR_HORA     = 8'h23;
  localparam logic [7:0] ADDR_DIA      = 8'h24;
  localparam logic [7:0] ADDR_MES      = 8'h25;
  localparam logic [7:0] ADDR_ANO      = 8'h26;
  localparam logic [7:0] ADDR_SEGUNDOT = 8'h41;
  localparam logic [7:0] ADDR_MINUTOT  = 8'h42;
  localparam logic [7:0] ADDR_HORAT    = 8'h43;

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT} scan_st_e;

  typedef enum logic [2:0] {F_IDLE, F_ADDR_P, F_ADDR_G, F_READ_P, F_READ_G} fase_st_e;

  function automatic logic [7:0] rtc_addr(input logic [3:0] idx);
    case (idx)
      IDX_SEGUNDO:  return ADDR_SEGUNDO;
      IDX_MINUTO:   return ADDR_MINUTO;
      IDX_HORA:     return ADDR_HORA;
      IDX_DIA:      return ADDR_DIA;
      IDX_MES:      return ADDR_MES;
      IDX_ANO:      return ADDR_ANO;
      IDX_SEGUNDOT: return ADDR_SEGUNDOT;
      IDX_MINUTOT:  return ADDR_MINUTOT;
      IDX_HORAT:    return ADDR_HORAT;
      default:      return 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/rtc_bus_fase.sv
// Single RTC access sequencer: address write phase then read phase, each a
// strobe pulse followed by an idle gap. Chains straight into the next access.
module rtc_bus_fase
  import rtc_pkg::*;
#(
  parameter int T_PULSE = 8,
  parameter int T_GAP   = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       go_i,
  input  logic [7:0] addr_i,
  output logic       cap_o,
  output logic       fin_o,
  output logic       cs_n_o,
  output logic       rd_n_o,
  output logic       wr_n_o,
  output logic       a_d_o,
  output logic       ad_oe_o,
  output logic [7:0] ad_out_o
);

  fase_st_e   st_q;
  logic [3:0] cnt_q;
  logic       cs_n_q, rd_n_q, wr_n_q, a_d_q, ad_oe_q;
  logic [7:0] ad_out_q;
  logic       p_end, g_end, launch;

  assign p_end  = (cnt_q == 4'(T_PULSE - 1));
  assign g_end  = (cnt_q == 4'(T_GAP - 1));
  assign cap_o  = (st_q == F_READ_P) && p_end;
  assign fin_o  = (st_q == F_READ_G) && g_end;
  // A new access may start from idle or directly off the last gap cycle.
  assign launch = go_i && ((st_q == F_IDLE) || fin_o);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q     <= F_IDLE;
      cnt_q    <= '0;
      cs_n_q   <= 1'b1;
      rd_n_q   <= 1'b1;
      wr_n_q   <= 1'b1;
      a_d_q    <= 1'b0;
      ad_oe_q  <= 1'b0;
      ad_out_q <= '0;
    end else begin
      cnt_q <= cnt_q + 4'd1;
      case (st_q)
        F_IDLE: cnt_q <= '0;
        F_ADDR_P: if (p_end) begin
          st_q   <= F_ADDR_G;
          cnt_q  <= '0;
          cs_n_q <= 1'b1;
          wr_n_q <= 1'b1;
        end
        F_ADDR_G: if (g_end) begin
          // Bus turnaround: release the drive on the same edge RD_N falls.
          st_q    <= F_READ_P;
          cnt_q   <= '0;
          cs_n_q  <= 1'b0;
          rd_n_q  <= 1'b0;
          a_d_q   <= 1'b1;
          ad_oe_q <= 1'b0;
        end
        F_READ_P: if (p_end) begin
          st_q   <= F_READ_G;
          cnt_q  <= '0;
          cs_n_q <= 1'b1;
          rd_n_q <= 1'b1;
        end
        F_READ_G: if (g_end) begin
          st_q  <= F_IDLE;
          cnt_q <= '0;
          a_d_q <= 1'b0;
        end
        default: st_q <= F_IDLE;
      endcase
      if (launch) begin
        st_q     <= F_ADDR_P;
        cnt_q    <= '0;
        cs_n_q   <= 1'b0;
        wr_n_q   <= 1'b0;
        a_d_q    <= 1'b0;
        ad_oe_q  <= 1'b1;
        ad_out_q <= addr_i;
      end
    end
  end

  assign cs_n_o   = cs_n_q;
  assign rd_n_o   = rd_n_q;
  assign wr_n_o   = wr_n_q;
  assign a_d_o    = a_d_q;
  assign ad_oe_o  = ad_oe_q;
  assign ad_out_o = ad_out_q;

endmodule

// File: rtl/rtc_lector_bus.sv
// Periodic RTC scanner: reads nine BCD registers into shadows and commits them
// in one cycle so the display never shows a half-updated date/time/timer.
module rtc_lector_bus
  import rtc_pkg::*;
#(
  parameter int REFRESH_CYCLES = 2_500_000,
  parameter int T_PULSE        = 8,
  parameter int T_GAP          = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       ALARMA_ACK,
  input  logic [7:0] AD_IN,
  output logic [7:0] AD_OUT,
  output logic       AD_OE,
  output logic       CS_N,
  output logic       RD_N,
  output logic       WR_N,
  output logic       A_D,
  output logic [7:0] DIA_T,
  output logic [7:0] MES_T,
  output logic [7:0] ANO_T,
  output logic [7:0] HORA_T,
  output logic [7:0] MINUTO_T,
  output logic [7:0] SEGUNDO_T,
  output logic [7:0] HORAT_T,
  output logic [7:0] MINUTOT_T,
  output logic [7:0] SEGUNDOT_T,
  output logic       BUSY,
  output logic       DONE,
  output logic       ALARMA
);

  localparam int PW = $clog2(REFRESH_CYCLES + 1);

  scan_st_e   st_q;
  logic [PW-1:0] per_q;
  logic [3:0] idx_q, go_idx;
  logic [7:0] shadow_q [NUM_REGS];
  logic [7:0] out_q    [NUM_REGS];
  logic       busy_q, done_q, alarma_q;
  logic       kick, go, cap, fin, tmr_zero_new, tmr_zero_old;
  logic [7:0] go_addr;

  assign kick   = (per_q == PW'(REFRESH_CYCLES - 1)) || START;
  assign go     = ((st_q == S_IDLE) && kick) || ((st_q == S_SCAN) && (idx_q != IDX_HORAT));
  // In SCAN the sequencer only takes go at the end of an access, so the next index.
  assign go_idx  = (st_q == S_SCAN) ? idx_q + 4'd1 : 4'd0;
  assign go_addr = rtc_addr(go_idx);

  assign tmr_zero_new = ({shadow_q[IDX_HORAT], shadow_q[IDX_MINUTOT], shadow_q[IDX_SEGUNDOT]} == 24'h0);
  assign tmr_zero_old = ({out_q[IDX_HORAT], out_q[IDX_MINUTOT], out_q[IDX_SEGUNDOT]} == 24'h0);

  rtc_bus_fase #(.T_PULSE(T_PULSE), .T_GAP(T_GAP)) u_fase (
    .clk_i    (CLK),
    .rst_i    (RST),
    .go_i     (go),
    .addr_i   (go_addr),
    .cap_o    (cap),
    .fin_o    (fin),
    .cs_n_o   (CS_N),
    .rd_n_o   (RD_N),
    .wr_n_o   (WR_N),
    .a_d_o    (A_D),
    .ad_oe_o  (AD_OE),
    .ad_out_o (AD_OUT)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q     <= S_IDLE;
      per_q    <= '0;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      alarma_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        shadow_q[i] <= '0;
        out_q[i]    <= '0;
      end
    end else begin
      done_q <= 1'b0;
      if (ALARMA_ACK) alarma_q <= 1'b0;
      case (st_q)
        S_IDLE: begin
          if (kick) begin
            st_q   <= S_SCAN;
            per_q  <= '0;
            idx_q  <= '0;
            busy_q <= 1'b1;
          end else begin
            per_q <= per_q + 1'b1;
          end
        end
        S_SCAN: begin
          if (cap) shadow_q[idx_q] <= AD_IN;
          if (fin) begin
            if (idx_q == IDX_HORAT) begin
              // Commit lands together with DONE; a new alarm overrides an ack.
              st_q   <= S_COMMIT;
              idx_q  <= '0;
              done_q <= 1'b1;
              for (int i = 0; i < NUM_REGS; i++) out_q[i] <= shadow_q[i];
              if (tmr_zero_new && !tmr_zero_old) alarma_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 4'd1;
            end
          end
        end
        S_COMMIT: begin
          st_q   <= S_IDLE;
          busy_q <= 1'b0;
        end
        default: st_q <= S_IDLE;
      endcase
    end
  end

  assign SEGUNDO_T  = out_q[IDX_SEGUNDO];
  assign MINUTO_T   = out_q[IDX_MINUTO];
  assign HORA_T     = out_q[IDX_HORA];
  assign DIA_T      = out_q[IDX_DIA];
  assign MES_T      = out_q[IDX_MES];
  assign ANO_T      = out_q[IDX_ANO];
  assign SEGUNDOT_T = out_q[IDX_SEGUNDOT];
  assign MINUTOT_T  = out_q[IDX_MINUTOT];
  assign HORAT_T    = out_q[IDX_HORAT];
  assign BUSY       = busy_q;
  assign DONE       = done_q;
  assign ALARMA     = alarma_q;

endmodule
